// File: rtl/feature_pkg.sv
// Shared types and helpers for the feature_selector slice (state encoding, widths, saturating subtract).
// The delta datapath is enabled with FEATURE_SELECTOR_DELTA_EN.
package feature_pkg;

  typedef enum logic {
    PASS  = 1'b0,
    DELTA = 1'b1
  } state_e;

  // Pointer width able to address n entries (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Counter width able to hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return int'($clog2(n + 1));
  endfunction

  // a - b clamped to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned     w);
    logic signed [63:0] d;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    d  = a - b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/feature_delta_buffer.sv
// Current/previous frame coefficient store for delta computation; read port returns the saturated difference.
module feature_delta_buffer
  import feature_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH       = 16,
  parameter  int unsigned NUM_FEATURES_OUT = 16,
  localparam int unsigned PTR_W            = ptr_w(NUM_FEATURES_OUT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         wr_en,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]             rd_ptr,
  input  logic                         copy_en,
  input  logic                         mark_valid,
  output logic signed [DATA_WIDTH-1:0] diff_c
);

  logic signed [DATA_WIDTH-1:0] cur  [NUM_FEATURES_OUT];
  logic signed [DATA_WIDTH-1:0] prev [NUM_FEATURES_OUT];
  logic                         prev_valid;

  // Storage is intentionally not reset; stale prev entries beyond a short frame persist.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      cur[wr_ptr] <= wr_data;
    end
    if (copy_en) begin
      prev[rd_ptr] <= cur[rd_ptr];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_valid <= 1'b0;
    end else if (mark_valid) begin
      prev_valid <= 1'b1;
    end
  end

  assign diff_c = prev_valid
                ? DATA_WIDTH'(sat_sub(64'(cur[rd_ptr]), 64'(prev[rd_ptr]), DATA_WIDTH))
                : '0;

endmodule

// File: rtl/feature_selector.sv
// Forwards a contiguous coefficient window per frame through a one-entry output register.
// Define FEATURE_SELECTOR_DELTA_EN to append first-order deltas against the previous frame.
module feature_selector
  import feature_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned N_COEFFS         = 32,
  parameter int unsigned FIRST_FEATURE    = 0,
  parameter int unsigned NUM_FEATURES_OUT = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic signed [DATA_WIDTH-1:0] coeff_data_in,
  input  logic                         coeff_valid_in,
  input  logic                         coeff_last_in,
  output logic                         coeff_ready_out,
  input  logic                         feature_ready_in,
  output logic                         feature_valid_out,
  output logic signed [DATA_WIDTH-1:0] feature_data_out,
  output logic                         feature_last_out,
  output logic                         short_frame_out
);

  localparam int unsigned IDX_W = ptr_w(N_COEFFS);
  localparam int unsigned CNT_W = cnt_w(NUM_FEATURES_OUT);

  localparam logic [IDX_W:0]   WIN_LO  = (IDX_W + 1)'(FIRST_FEATURE);
  localparam logic [IDX_W:0]   WIN_LEN = (IDX_W + 1)'(NUM_FEATURES_OUT);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_COEFFS - 1);
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(NUM_FEATURES_OUT - 1);
  localparam logic [CNT_W-1:0] K_FULL  = CNT_W'(NUM_FEATURES_OUT);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] k;

  logic slot_free_c;
  logic accept_c;
  logic in_win_c;
  logic kept_c;

  assign slot_free_c     = !feature_valid_out || feature_ready_in;
  assign coeff_ready_out = !rst_in && (state == PASS) && slot_free_c;
  assign accept_c        = coeff_valid_in && coeff_ready_out;

  // Offset compare: indices below the window wrap to large values and fall outside.
  assign in_win_c = (({1'b0, idx} - WIN_LO) < WIN_LEN);
  assign kept_c   = in_win_c && (k < K_FULL);

`ifdef FEATURE_SELECTOR_DELTA_EN
  localparam int unsigned PTR_W = ptr_w(NUM_FEATURES_OUT);

  logic [CNT_W-1:0]             j;
  logic [CNT_W-1:0]             k_total;
  logic [CNT_W-1:0]             k_final_c;
  logic                         last_j_c;
  logic                         copy_c;
  logic signed [DATA_WIDTH-1:0] diff_c;

  assign k_final_c = k + CNT_W'(kept_c);
  assign last_j_c  = (j == k_total - CNT_W'(1));
  assign copy_c    = (state == DELTA) && slot_free_c;

  feature_delta_buffer #(
    .DATA_WIDTH       (DATA_WIDTH),
    .NUM_FEATURES_OUT (NUM_FEATURES_OUT)
  ) u_delta_buf (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_en      (accept_c && kept_c),
    .wr_ptr     (PTR_W'(k)),
    .wr_data    (coeff_data_in),
    .rd_ptr     (PTR_W'(j)),
    .copy_en    (copy_c),
    .mark_valid (copy_c && last_j_c),
    .diff_c     (diff_c)
  );
`endif

  // Frame indexing, window selection, output register and delta sequencing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= PASS;
      idx               <= '0;
      k                 <= '0;
      feature_valid_out <= 1'b0;
      feature_data_out  <= '0;
      feature_last_out  <= 1'b0;
      short_frame_out   <= 1'b0;
`ifdef FEATURE_SELECTOR_DELTA_EN
      j                 <= '0;
      k_total           <= '0;
`endif
    end else begin
      short_frame_out <= 1'b0;
      if (feature_valid_out && feature_ready_in) begin
        feature_valid_out <= 1'b0;
      end

      case (state)
        PASS: begin
          if (accept_c) begin
            if (kept_c) begin
              feature_valid_out <= 1'b1;
              feature_data_out  <= coeff_data_in;
`ifdef FEATURE_SELECTOR_DELTA_EN
              feature_last_out  <= 1'b0;
`else
              feature_last_out  <= (k == K_LAST) || coeff_last_in;
`endif
              k <= k + CNT_W'(1);
            end

            if (coeff_last_in) begin
              idx <= '0;
              k   <= '0;
`ifdef FEATURE_SELECTOR_DELTA_EN
              if (k_final_c == '0) begin
                short_frame_out <= 1'b1;
              end else begin
                state   <= DELTA;
                j       <= '0;
                k_total <= k_final_c;
              end
`else
              if ((k == '0) && !kept_c) begin
                short_frame_out <= 1'b1;
              end
`endif
            end else if (idx != IDX_MAX) begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

`ifdef FEATURE_SELECTOR_DELTA_EN
        // One delta per free output slot; the final delta closes the output frame.
        DELTA: begin
          if (slot_free_c) begin
            feature_valid_out <= 1'b1;
            feature_data_out  <= diff_c;
            feature_last_out  <= last_j_c;
            j                 <= j + CNT_W'(1);
            if (last_j_c) begin
              state <= PASS;
            end
          end
        end
`endif

        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_selector.sv
// Randomized bench for feature_selector: several parameterisations run side by side against a frame-level model.
module tb_feature_selector;

`ifdef FEATURE_SELECTOR_DELTA_EN
  localparam bit DELTA = 1'b1;
  localparam int NI    = 4;
`else
  localparam bit DELTA = 1'b0;
  localparam int NI    = 3;
`endif

  function automatic int first_of(input int g);
    case (g)
      1:       return 1;
      2:       return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int num_of(input int g);
    case (g)
      1:       return 12;
      3:       return 4;
      default: return 16;
    endcase
  endfunction

  typedef logic signed [15:0] wq_t[$];
  typedef struct packed {
    logic signed [15:0] d;
    logic               last;
    logic               dl;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  wire [NI-1:0] done_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] sat16(input int v);
    if (v > 32767)  return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic wq_t seq_q(input int n, input int base);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'(base + i));
    return q;
  endfunction

  function automatic wq_t rnd_q(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom));
    return q;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int FF = first_of(g);
    localparam int NF = num_of(g);

    logic               rst, vin, lin, rdy_out, frdy, fval, flast, shrt;
    logic signed [15:0] din, fdata;

    feature_selector #(
      .DATA_WIDTH       (16),
      .N_COEFFS         (32),
      .FIRST_FEATURE    (FF),
      .NUM_FEATURES_OUT (NF)
    ) u_dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .coeff_data_in     (din),
      .coeff_valid_in    (vin),
      .coeff_last_in     (lin),
      .coeff_ready_out   (rdy_out),
      .feature_ready_in  (frdy),
      .feature_valid_out (fval),
      .feature_data_out  (fdata),
      .feature_last_out  (flast),
      .short_frame_out   (shrt)
    );

    item_t              expq[$];
    logic signed [15:0] cur_m[$];
    logic signed [15:0] prev_m [NF];
    bit                 prev_ok, lat_pend, done, rmode;
    int                 pos, short_exp, short_seen, unloaded;

    assign done_w[g] = done;

    function automatic string tg(input string s);
      return $sformatf("g%0d_%s", g, s);
    endfunction

    // Frame-level reference: window by position, deltas computed once the frame closes.
    task automatic model_accept(input logic signed [15:0] d, input bit l);
      if (pos >= FF && pos < FF + NF) begin
        cur_m.push_back(d);
        expq.push_back('{d: d, last: (!DELTA) && (l || (pos == FF + NF - 1)), dl: 1'b0});
        lat_pend = 1'b1;
      end
      pos++;
      if (l) begin
        if (cur_m.size() == 0) begin
          short_exp++;
        end else if (DELTA) begin
          for (int j = 0; j < cur_m.size(); j++) begin
            expq.push_back('{d: prev_ok ? sat16(int'(cur_m[j]) - int'(prev_m[j])) : 16'sd0,
                             last: (j == cur_m.size() - 1), dl: 1'b1});
            prev_m[j] = cur_m[j];
          end
          prev_ok = 1'b1;
        end
        cur_m.delete();
        pos = 0;
      end
    endtask

    task automatic step(input bit v, input logic signed [15:0] d, input bit l, output bit acc);
      @(negedge clk);
      if (lat_pend) check(tg("latency"), 32'(fval), 32'(1));
      lat_pend = 1'b0;
      if (shrt) short_seen++;
      unloaded = 0;
      foreach (expq[i]) if (expq[i].dl) unloaded++;
      if (fval) begin
        if (expq.size() == 0) begin
          check(tg("extra_out"), 32'(fval), 32'(0));
        end else begin
          check(tg("data"), 32'($unsigned(fdata)), 32'($unsigned(expq[0].d)));
          check(tg("last"), 32'(flast), 32'(expq[0].last));
          if (expq[0].dl) unloaded--;
        end
      end
      vin  = v;
      din  = d;
      lin  = l;
      frdy = rmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (unloaded > 0) check(tg("ready_in_delta"), 32'(rdy_out), 32'(0));
      if (fval && frdy && expq.size() > 0) void'(expq.pop_front());
      acc = v && rdy_out;
      if (acc) model_accept(d, l);
    endtask

    task automatic send(input wq_t w, input int stop_after, input bit bubbles);
      bit acc;
      int tries;
      for (int i = 0; i < w.size(); i++) begin
        if (stop_after >= 0 && i == stop_after) return;
        acc   = 1'b0;
        tries = 0;
        while (!acc) begin
          step(bubbles ? ($urandom_range(0, 3) != 0) : 1'b1, w[i], (i == w.size() - 1), acc);
          tries++;
          if (!acc && tries > 300) begin
            check(tg("accept_timeout"), 32'(acc), 32'(1));
            return;
          end
        end
      end
    endtask

    task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      vin = 1'b0;
      #1;
      check(tg("rst_valid"), 32'(fval), 32'(0));
      check(tg("rst_data"), 32'($unsigned(fdata)), 32'(0));
      check(tg("rst_last"), 32'(flast), 32'(0));
      check(tg("rst_ready"), 32'(rdy_out), 32'(0));
      expq.delete();
      cur_m.delete();
      pos      = 0;
      prev_ok  = 1'b0;
      lat_pend = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic start();
      rst = 1'b1; vin = 1'b0; din = '0; lin = 1'b0; frdy = 1'b0;
      rmode = 1'b0; done = 1'b0; pos = 0; prev_ok = 1'b0; lat_pend = 1'b0;
      short_exp = 0; short_seen = 0;
      repeat (2) @(negedge clk);
      check(tg("init_valid"), 32'(fval), 32'(0));
      check(tg("init_data"), 32'($unsigned(fdata)), 32'(0));
      check(tg("init_last"), 32'(flast), 32'(0));
      check(tg("init_short"), 32'(shrt), 32'(0));
      check(tg("init_ready"), 32'(rdy_out), 32'(0));
      rst = 1'b0;
    endtask

    task automatic finish_run();
      bit acc;
      repeat (4) step(1'b0, 16'sd0, 1'b0, acc);
      for (int c = 0; c < 400 && expq.size() > 0; c++) step(1'b0, 16'sd0, 1'b0, acc);
      check(tg("drain"), 32'(expq.size()), 32'(0));
      check(tg("short_count"), 32'(short_seen), 32'(short_exp));
      done = 1'b1;
    endtask

    if (g == 0) begin : p_default
      initial begin
        start();
        send(seq_q(32, 0), -1, 1'b0);
        send(seq_q(5, 100), -1, 1'b0);
        send(seq_q(32, 0), -1, 1'b0);
        send(seq_q(32, 200), 7, 1'b0);
        do_reset();
        send(seq_q(32, 0), -1, 1'b0);
        rmode = 1'b1;
        repeat (6) send(rnd_q($urandom_range(1, 40)), -1, 1'b1);
        finish_run();
      end
    end else if (g == 1) begin : p_window
      initial begin
        start();
        rmode = 1'b1;
        send(seq_q(32, 0), -1, 1'b1);
        send(seq_q(40, 0), -1, 1'b1);
        repeat (8) send(rnd_q($urandom_range(1, 40)), -1, 1'b1);
        finish_run();
      end
    end else if (g == 2) begin : p_short
      initial begin
        start();
        rmode = 1'b1;
        send(seq_q(5, 0), -1, 1'b0);
        send(seq_q(32, 0), -1, 1'b1);
        repeat (6) send(rnd_q($urandom_range(1, 40)), -1, 1'b1);
        finish_run();
      end
    end else begin : p_delta
      initial begin
        wq_t fa;
        wq_t fb;
        fa = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
        fb = '{16'sd15, 16'sd10, 16'sd30, 16'sh8000};
        start();
        send(fa, -1, 1'b0);
        send(fb, -1, 1'b0);
        send(rnd_q(40), -1, 1'b0);
        rmode = 1'b1;
        repeat (6) send(rnd_q($urandom_range(1, 40)), -1, 1'b1);
        finish_run();
      end
    end
  end

  initial begin
    for (int c = 0; c < 50000 && done_w != '1; c++) @(posedge clk);
    if (done_w != '1) check("timeout", 32'(done_w), 32'((1 << NI) - 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
